// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Multi-mode test-pattern source placed between a video timing
//                core and its rgb input. Patterns: solid, border/box, colour
//                bars, gradient, bouncing box, checkerboard. The mode is
//                sampled at frame start only. de/hsync/vsync are delayed by
//                two clocks so they stay aligned with the registered rgb.
//                Optional build macro VIDEO_PATGEN_CURSOR_EN adds a white
//                crosshair through the bouncing-box centre (modes 0-5).
//  Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen #(
    parameter int          WB     = 9,
    parameter int          SW     = 720,
    parameter int          SH     = 480,
    parameter int          BOX_W  = 64,
    parameter int          BOX_H  = 48,
    parameter int          STEP   = 2,
    parameter int          CHK_LG = 4,
    parameter logic [23:0] COLOR  = 24'h0000ff
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WB:0]   sx,
    input  logic [WB:0]   sy,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [2:0]    mode,
    output logic [23:0]   rgb,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [7:0]    frame_cnt
);

    // Coordinate constants are widened by one bit so SW/SH never truncate.
    localparam int                 c_BAR_W  = SW / 8;
    localparam logic [WB+1:0]      c_SW     = (WB+2)'(SW);
    localparam logic [WB+1:0]      c_SH     = (WB+2)'(SH);
    localparam logic [WB:0]        c_SW_M1  = (WB+1)'(SW - 1);
    localparam logic [WB:0]        c_SH_M1  = (WB+1)'(SH - 1);
    localparam logic [WB:0]        c_IN_LO  = (WB+1)'(100);
    localparam logic [WB:0]        c_IN_XHI = (WB+1)'(SW - 100);
    localparam logic [WB:0]        c_IN_YHI = (WB+1)'(SH - 100);
    localparam logic signed [WB+1:0] c_XMAX = (WB+2)'(SW - BOX_W);
    localparam logic signed [WB+1:0] c_YMAX = (WB+2)'(SH - BOX_H);
    localparam logic signed [WB+1:0] c_STEP = (WB+2)'(STEP);
    localparam logic [WB+1:0]      c_BOX_W  = (WB+2)'(BOX_W);
    localparam logic [WB+1:0]      c_BOX_H  = (WB+2)'(BOX_H);
    localparam logic [23:0]        c_WHITE  = 24'hffffff;

    // Frame-level state
    logic [2:0]          mode_q, mode_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [WB:0]         box_x_q, box_x_d, box_y_q, box_y_d;
    logic                dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards 0

    // Pipeline
    logic [23:0]         pix_q, pix_d;
    logic [23:0]         rgb_q, rgb_d;
    logic [2:0]          sync1_q, sync1_d;         // {de, hsync, vsync}
    logic [2:0]          sync2_q, sync2_d;

    // Combinational helpers
    logic                frame_start;
    logic signed [WB+1:0] nx, ny;
    logic [2:0]          mode_eff;
    logic [WB:0]         x_eff, y_eff;
    logic                in_range, on_edge, in_inner, in_box, chk_bit;
    logic [3:0]          bar;
    logic [23:0]         bar_rgb, pat;

`ifdef VIDEO_PATGEN_CURSOR_EN
    logic [WB:0]         cur_x, cur_y;
`endif

    // Frame-start detection, mode latch, frame counter and box motion
    always_comb begin
        frame_start = de_in && (sx == '0) && (sy == '0);
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        box_x_d     = box_x_q;
        box_y_d     = box_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        nx = dx_q ? ($signed({1'b0, box_x_q}) - c_STEP) : ($signed({1'b0, box_x_q}) + c_STEP);
        ny = dy_q ? ($signed({1'b0, box_y_q}) - c_STEP) : ($signed({1'b0, box_y_q}) + c_STEP);
        if (frame_start) begin
            mode_d      = mode;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!dx_q && (nx > c_XMAX)) begin
                box_x_d = c_XMAX[WB:0];
                dx_d    = 1'b1;
            end else if (dx_q && nx[WB+1]) begin
                box_x_d = '0;
                dx_d    = 1'b0;
            end else begin
                box_x_d = nx[WB:0];
            end
            if (!dy_q && (ny > c_YMAX)) begin
                box_y_d = c_YMAX[WB:0];
                dy_d    = 1'b1;
            end else if (dy_q && ny[WB+1]) begin
                box_y_d = '0;
                dy_d    = 1'b0;
            end else begin
                box_y_d = ny[WB:0];
            end
        end
    end

    // Pattern decode for the current pixel; frame-start pixel already uses the new mode/box
    always_comb begin
        mode_eff = frame_start ? mode    : mode_q;
        x_eff    = frame_start ? box_x_d : box_x_q;
        y_eff    = frame_start ? box_y_d : box_y_q;

        in_range = ({1'b0, sx} < c_SW) && ({1'b0, sy} < c_SH);
        on_edge  = (sx == '0) || (sx == c_SW_M1) || (sy == '0) || (sy == c_SH_M1);
        in_inner = (sx >= c_IN_LO) && (sx < c_IN_XHI) && (sy >= c_IN_LO) && (sy < c_IN_YHI);
        in_box   = ({1'b0, sx} >= {1'b0, x_eff}) && ({1'b0, sx} < ({1'b0, x_eff} + c_BOX_W)) &&
                   ({1'b0, sy} >= {1'b0, y_eff}) && ({1'b0, sy} < ({1'b0, y_eff} + c_BOX_H));
        chk_bit  = sx[CHK_LG] ^ sy[CHK_LG];

        // Comparator chain against constant bar boundaries
        bar = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if ({1'b0, sx} >= (WB+2)'(k * c_BAR_W)) begin
                bar = 4'(k);
            end
        end
        case (bar)
            4'd0:    bar_rgb = 24'hffffff;
            4'd1:    bar_rgb = 24'hffff00;
            4'd2:    bar_rgb = 24'h00ffff;
            4'd3:    bar_rgb = 24'h00ff00;
            4'd4:    bar_rgb = 24'hff00ff;
            4'd5:    bar_rgb = 24'hff0000;
            4'd6:    bar_rgb = 24'h0000ff;
            default: bar_rgb = 24'h000000;
        endcase

        case (mode_eff)
            3'd0:    pat = COLOR;
            3'd1:    pat = (on_edge || in_inner) ? c_WHITE : COLOR;
            3'd2:    pat = bar_rgb;
            3'd3:    pat = {sy[7:0], sx[7:0], 8'h00};
            3'd4:    pat = in_box ? c_WHITE : COLOR;
            3'd5:    pat = chk_bit ? c_WHITE : 24'h000000;
            default: pat = 24'h000000;
        endcase

`ifdef VIDEO_PATGEN_CURSOR_EN
        cur_x = x_eff + (WB+1)'(BOX_W / 2);
        cur_y = y_eff + (WB+1)'(BOX_H / 2);
        if ((mode_eff <= 3'd5) && ((sx == cur_x) || (sy == cur_y))) begin
            pat = c_WHITE;
        end
`endif

        // Coordinates outside the active area are blanked even if de_in is high
        pix_d   = in_range ? pat : 24'h000000;
        sync1_d = {de_in, hsync_in, vsync_in};
        sync2_d = sync1_q;
        rgb_d   = sync1_q[2] ? pix_q : 24'h000000;
    end

    // State and two-stage pipeline registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= 3'd0;
            frame_cnt_q <= 8'd0;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dx_q        <= 1'b0;
            dy_q        <= 1'b0;
            pix_q       <= 24'h000000;
            rgb_q       <= 24'h000000;
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
        end else begin
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            pix_q       <= pix_d;
            rgb_q       <= rgb_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign rgb       = rgb_q;
    assign de_out    = sync2_q[2];
    assign hsync_out = sync2_q[1];
    assign vsync_out = sync2_q[0];
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
